// File: rtl/mem_pipe_4cyc_pkg.sv
// Shared types and constants for the pipelined main-memory model.
package mem_pkg;
  localparam int MEM_ADDR_W      = 16;
  localparam int MEM_DATA_W      = 16;
  localparam int MEM_LATENCY     = 4;
  localparam int MEM_BLOCK_WORDS = 8;

  typedef logic [MEM_DATA_W-1:0] mem_word_t;

  typedef struct packed {
    logic      valid;
    mem_word_t data;
  } pipe_slot_t;

  function automatic logic [MEM_ADDR_W-2:0] word_index(input logic [MEM_ADDR_W-1:0] addr);
    logic unused_lsb;
    logic [MEM_ADDR_W-2:0] idx;
    {idx, unused_lsb} = addr;
    return idx;
  endfunction
endpackage

// File: rtl/mem_pipe_4cyc_if.sv
// Request/response bundle between the fill controller and the memory model.
// `busy` exists only when MEM_BUSY_EN is defined.
interface mem_pipe_4cyc_if;
  import mem_pkg::*;

  logic                  enable;
  logic                  wr;
  logic [MEM_ADDR_W-1:0] addr;
  mem_word_t             data_in;
  mem_word_t             data_out;
  logic                  data_valid;
`ifdef MEM_BUSY_EN
  logic                  busy;

  modport master (output enable, wr, addr, data_in, input data_out, data_valid, busy);
  modport slave  (input enable, wr, addr, data_in, output data_out, data_valid, busy);
`else
  modport master (output enable, wr, addr, data_in, input data_out, data_valid);
  modport slave  (input enable, wr, addr, data_in, output data_out, data_valid);
`endif
endinterface

// File: rtl/mem_pipe_4cyc_lat_pipe.sv
// Read-return shift pipeline: slot 0 captures the word at issue, so the last
// slot (index LATENCY) presents it exactly LATENCY edges later.
module mem_lat_pipe
  import mem_pkg::*;
#(
  parameter int LATENCY = MEM_LATENCY
) (
  input  logic               clk,
  input  logic               rst,
  input  pipe_slot_t         slot_i,
  output pipe_slot_t         slot_o,
  output logic [LATENCY:0]   vld_o
);
  pipe_slot_t [LATENCY:0] slot_q, slot_d;

  always_comb begin
    slot_d    = slot_q;
    slot_d[0] = slot_i;
    for (int k = 1; k <= LATENCY; k++) slot_d[k] = slot_q[k-1];
  end

  always_ff @(posedge clk) begin
    if (rst) slot_q <= '0;
    else     slot_q <= slot_d;
  end

  assign slot_o = slot_q[LATENCY];

  for (genvar k = 0; k <= LATENCY; k++) begin : g_vld
    assign vld_o[k] = slot_q[k].valid;
  end
endmodule

// File: rtl/mem_pipe_4cyc.sv
// Pipelined main-memory model: one request per cycle, fixed-latency read
// strobes, snapshot read semantics. Optional `busy` output via MEM_BUSY_EN.
module mem_pipe_4cyc
  import mem_pkg::*;
#(
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W,
  parameter int LATENCY = MEM_LATENCY
) (
  input  logic clk,
  input  logic rst,
  mem_pipe_4cyc_if.slave bus
);
  if (LATENCY < 1 || LATENCY > 8 || ADDR_W != MEM_ADDR_W || DATA_W != MEM_DATA_W) begin : g_bad_cfg
    $error("mem_pipe_4cyc: illegal configuration (LATENCY must be 1..8, widths must match mem_pkg)");
  end

  mem_word_t          mem_q [2**(ADDR_W-1)];
  logic [ADDR_W-2:0]  idx;
  pipe_slot_t         slot0_d, out_slot;
  logic [LATENCY:0]   vld;

  assign idx = word_index(bus.addr);

  // Contents survive reset; requests coinciding with rst are dropped.
  always_ff @(posedge clk) begin
    if (!rst && bus.enable && bus.wr) mem_q[idx] <= bus.data_in;
  end

  // Reading the pre-edge array value gives the snapshot: a later write cannot
  // reach a word already in the pipeline.
  always_comb begin
    slot0_d.valid = bus.enable & ~bus.wr;
    slot0_d.data  = slot0_d.valid ? mem_q[idx] : '0;
  end

  mem_lat_pipe #(.LATENCY(LATENCY)) u_pipe (
    .clk    (clk),
    .rst    (rst),
    .slot_i (slot0_d),
    .slot_o (out_slot),
    .vld_o  (vld)
  );

  assign bus.data_valid = out_slot.valid;
  assign bus.data_out   = out_slot.valid ? out_slot.data : '0;

`ifdef MEM_BUSY_EN
  assign bus.busy = |vld;
`else
  logic unused_vld;
  assign unused_vld = |vld;
`endif
endmodule

// File: tb/tb_mem_pipe_4cyc.sv
// Directed, table-driven bench for mem_pipe_4cyc; busy checked when MEM_BUSY_EN is defined.
module tb_mem_pipe_4cyc;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_pipe_4cyc_if bus();

  mem_pipe_4cyc #(.ADDR_W(MEM_ADDR_W), .DATA_W(MEM_DATA_W), .LATENCY(MEM_LATENCY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rst;
    logic        en;
    logic        wr;
    logic [15:0] addr;
    mem_word_t   din;
    logic        ev;
    mem_word_t   ed;
    logic        eb;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(input logic r, input logic e, input logic w,
                              input logic [15:0] a, input mem_word_t d);
    vec_t v;
    v.rst = r; v.en = e; v.wr = w; v.addr = a; v.din = d;
    v.ev = 1'b0; v.ed = '0; v.eb = 1'b0;
    tbl.push_back(v);
  endfunction

  function automatic void idle(input int n);
    for (int k = 0; k < n; k++) add(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
  endfunction

  function automatic void strobe(input int i, input mem_word_t d);
    tbl[i].ev = 1'b1;
    tbl[i].ed = d;
  endfunction

  function automatic void busy_span(input int i, input int n);
    for (int k = 0; k < n; k++) tbl[i+k].eb = 1'b1;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  initial begin
    int r, s, n;

    // Reset 2 cycles then idle 10.
    add(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    add(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    idle(10);

    // Single read latency; read directly follows the write.
    add(1'b0, 1'b1, 1'b1, 16'h0040, 16'hBEEF);
    r = tbl.size();
    add(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0);
    idle(6);
    strobe(r+4, 16'hBEEF);
    busy_span(r, 5);

    // Block fill: 8 writes, 8 back-to-back reads.
    for (int i = 0; i < 8; i++) add(1'b0, 1'b1, 1'b1, 16'(16'hCA50 + 2*i), 16'(16'h1000 + i));
    r = tbl.size();
    for (int i = 0; i < 8; i++) add(1'b0, 1'b1, 1'b0, 16'(16'hCA50 + 2*i), 16'h0);
    idle(6);
    for (int i = 0; i < 8; i++) strobe(r+4+i, 16'(16'h1000 + i));
    busy_span(r, 12);

    // Snapshot hazard.
    add(1'b0, 1'b1, 1'b1, 16'h0010, 16'h1111);
    r = tbl.size();
    add(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0);
    add(1'b0, 1'b1, 1'b1, 16'h0010, 16'h2222);
    add(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0);
    idle(7);
    strobe(r+4, 16'h1111);
    strobe(r+6, 16'h2222);
    busy_span(r, 7);

    // Reset mid-flight with a coincident write that must be dropped.
    add(1'b0, 1'b1, 1'b1, 16'h0020, 16'h5555);
    idle(5);
    r = tbl.size();
    add(1'b0, 1'b1, 1'b0, 16'h0030, 16'h0);
    add(1'b0, 1'b1, 1'b0, 16'h0032, 16'h0);
    add(1'b1, 1'b1, 1'b1, 16'h0020, 16'h3333);
    idle(6);
    busy_span(r, 2);
    s = tbl.size();
    add(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0);
    idle(5);
    strobe(s+4, 16'h5555);
    busy_span(s, 5);

    // Odd address maps to the same word.
    add(1'b0, 1'b1, 1'b1, 16'h0081, 16'hABCD);
    r = tbl.size();
    add(1'b0, 1'b1, 1'b0, 16'h0080, 16'h0);
    idle(5);
    strobe(r+4, 16'hABCD);
    busy_span(r, 5);

    rst = 1'b1; bus.enable = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.data_in = '0;

    foreach (tbl[i]) begin
      rst         = tbl[i].rst;
      bus.enable  = tbl[i].en;
      bus.wr      = tbl[i].wr;
      bus.addr    = tbl[i].addr;
      bus.data_in = tbl[i].din;
      @(posedge clk); #1;
      check($sformatf("valid[%0d]", i), 32'(bus.data_valid), 32'(tbl[i].ev));
      check($sformatf("data[%0d]", i), 32'(bus.data_out), 32'(tbl[i].ed));
`ifdef MEM_BUSY_EN
      check($sformatf("busy[%0d]", i), 32'(bus.busy), 32'(tbl[i].eb));
`endif
    end

    // Hand-written: measure read latency with a bounded wait.
    rst = 1'b0; bus.enable = 1'b1; bus.wr = 1'b0; bus.addr = 16'h0040;
    @(posedge clk); #1;
    bus.enable = 1'b0;
    n = 0;
    while (!bus.data_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 32'(n), 32'(MEM_LATENCY));
    check("latency_data", 32'(bus.data_out), 32'hBEEF);
    @(posedge clk); #1;
    check("strobe_one_cycle", 32'(bus.data_valid), 32'h0);
    check("data_zero_after", 32'(bus.data_out), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_pipe_4cyc.md
# mem_pipe_4cyc

Pipelined main-memory model that sits directly downstream of the cache fill controller: it accepts the controller's 16-bit word addresses, one per cycle, and returns each read word with a one-cycle `data_valid` strobe a fixed LATENCY cycles later. It also services single-cycle word writes from the cache write-through path. This lets an 8-word block fill issue back-to-back reads and receive 8 consecutive valid strobes.

## Interface
- ADDR_W, 16: byte address width; word index is addr[ADDR_W-1:1].
- DATA_W, 16: word width.
- LATENCY, 4: read latency in clock edges; legal range 1..8.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset; one clock; reset is synchronous and active-high.
- enable  in  1  request valid this cycle.
- wr  in  1  with enable: 1 = write, 0 = read.
- addr  in  ADDR_W  byte address; addr[0] ignored.
- data_in  in  DATA_W  write data.
- data_out  out  DATA_W  returned read word; 0 whenever data_valid is 0.
- data_valid  out  1  one-cycle strobe per completed read.
- busy  out  1  present only under MEM_BUSY_EN (see Configuration).

## Operation
- Array: 2^(ADDR_W-1) words of DATA_W bits. Contents are not cleared by rst; they are undefined until written.
- Read (enable=1, wr=0, rst=0 at edge E0):
  - Word mem[addr[ADDR_W-1:1]] is captured at E0 (snapshot semantics).
  - The captured word enters a LATENCY-deep valid/data shift pipeline.
- Write (enable=1, wr=1, rst=0 at edge E0):
  - data_in is stored at E0.
  - No strobe is produced and no pipeline slot is used.
- Snapshot rule: a write issued after a read, but before that read returns, does not change the read's returned value. A read issued one cycle after a write returns the new data.
- Throughput: one request per cycle with no backpressure, so at most LATENCY reads are in flight. Reads and writes may interleave freely; data_valid strobes keep issue order.
- Pipeline states per slot: EMPTY or FULL(word). Slot 0 loads on a read and clears otherwise. Slot k loads from slot k-1 every edge. The last slot drives data_valid/data_out.
- Reset: rst at an edge clears every slot to EMPTY. Requests presented at that same edge are ignored, including writes (the array is not modified). In-flight reads are discarded and never strobe.
- Out-of-range LATENCY: elaboration error.

## Timing
- Reset values: data_valid=0, data_out=0, busy=0.
- A read sampled at edge E0 gives data_valid=1 and data_out=word during the cycle between edges E_LATENCY and E_LATENCY+1. That is exactly LATENCY cycles after issue, for exactly one cycle.
- Consecutive reads at E0..E7 give 8 consecutive strobe cycles starting after E_LATENCY, with no gaps.
- A write is visible to a read sampled at the next edge. It is not visible to a read sampled at the same edge, which is impossible because there is one port.
- Fill controller contract: the controller advances its counter on each data_valid. A finished fill means the 8th strobe.

## Configuration
- MEM_BUSY_EN defined: adds output `busy`.
  - busy=1 in any cycle where at least one pipeline slot is FULL, including the strobe cycle itself. Otherwise busy=0.
  - busy is cleared by rst.
- MEM_BUSY_EN undefined: the `busy` port and its OR-reduction logic are absent. All other behaviour is identical.

## Structure
- Package mem_pkg:
  - constants MEM_ADDR_W=16, MEM_DATA_W=16, MEM_LATENCY=4, MEM_BLOCK_WORDS=8;
  - typedef mem_word_t (DATA_W bits);
  - typedef pipe_slot_t {valid, mem_word_t data};
  - function word_index(addr) returning addr[ADDR_W-1:1].
- Sub-module mem_lat_pipe: a parameterized LATENCY-deep shift register of pipe_slot_t with synchronous clear. The top level holds the array, decode and optional busy logic.

## Test plan
- Reset: hold rst 2 cycles, then idle 10 cycles -> data_valid=0 and data_out=0 throughout; busy=0 if built.
- Single read latency: write 0xBEEF to 0x0040; read 0x0040 at E0 -> data_valid=1, data_out=0xBEEF only in the cycle after E4; busy high E1..E4 strobe cycle.
- Block fill: write 0x1000+i to 0xCA50+2i for i=0..7; read them back-to-back at E0..E7 -> 8 contiguous strobes after E4..E11 returning 0x1000..0x1007 in order.
- Snapshot hazard: mem[0x0010]=0x1111; read 0x0010 at E0, write 0x2222 at E1, read again at E2 -> strobe after E4 gives 0x1111, strobe after E6 gives 0x2222.
- Reset mid-flight: reads issued at E0 and E1, with rst asserted at E2 along with a write of 0x3333 to 0x0020 -> no strobes at all, and a later read of 0x0020 returns its prior value.
- Odd address: write 0xABCD to 0x0081, read 0x0080 -> returns 0xABCD.
